iic_eeprom_sched: RTL

//  Two-requester scheduler in front of the single-byte EEPROM I2C engine (iCall/iAddr/idata/odata/oDone).

---
 rtl/iic_pkg.sv | 21 ++
 rtl/iic_eeprom_sched_if.sv | 41 ++++
 rtl/iic_rr_arb2.sv | 15 +
 rtl/iic_eeprom_sched.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/iic_pkg.sv
// Shared definitions for the EEPROM I2C scheduler: engine call codes,
// scheduler state encoding and the call-code helper.
package iic_pkg;

    localparam logic [1:0] CALL_IDLE = 2'b00;
    localparam logic [1:0] CALL_RD   = 2'b01;
    localparam logic [1:0] CALL_WR   = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ABORT = 2'd2,
        ST_GAP   = 2'd3
    } sched_state_t;

    // Only ever returns one of the two one-hot codes, so 2'b11 cannot reach the engine.
    function automatic logic [1:0] call_code(input logic we);
        return we ? CALL_WR : CALL_RD;
    endfunction

endpackage

// File: rtl/iic_eeprom_sched_if.sv
// Requester and engine-side signal bundle of the scheduler.
// The slave modport is the scheduler; the master modport is the surrounding system.
interface iic_eeprom_sched_if;

    logic       req0;
    logic       req1;
    logic       we0;
    logic       we1;
    logic [7:0] addr0;
    logic [7:0] addr1;
    logic [7:0] wdata0;
    logic [7:0] wdata1;
    logic       done0;
    logic       done1;
    logic       err0;
    logic       err1;
    logic [7:0] rdata;

    logic [1:0] iic_call;
    logic [7:0] iic_addr;
    logic [7:0] iic_wdata;
    logic [7:0] iic_rdata;
    logic       iic_done;
    logic       iic_rst_n;
    logic       busy;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  iic_rdata, iic_done,
        output done0, done1, err0, err1, rdata,
        output iic_call, iic_addr, iic_wdata, iic_rst_n, busy
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        output iic_rdata, iic_done,
        input  done0, done1, err0, err1, rdata,
        input  iic_call, iic_addr, iic_wdata, iic_rst_n, busy
    );

endinterface

// File: rtl/iic_rr_arb2.sv
// Two-way round-robin picker: the requester named by i_ptr wins a tie,
// a lone requester always wins. Output is one-hot or zero.
module iic_rr_arb2 (
    input  logic [1:0] i_req,
    input  logic       i_ptr,
    output logic [1:0] o_gnt
);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_gnt
            assign o_gnt[gi] = i_req[gi] & ((i_ptr == 1'(gi)) | ~i_req[1 - gi]);
        end
    endgenerate

endmodule

// File: rtl/iic_eeprom_sched.sv
// Round-robin scheduler for two requesters in front of the single-byte EEPROM
// I2C engine, with post-write tWR gap and timeout abort of a hung transfer.
module iic_eeprom_sched
    import iic_pkg::*;
#(
    parameter logic [31:0] TIMEOUT_CYC = 32'd250000,
    parameter logic [31:0] WR_GAP_CYC  = 32'd250000,
    parameter logic [7:0]  ABORT_CYC   = 8'd4
) (
    input  logic              clk,
    input  logic              rst_n,
    iic_eeprom_sched_if.slave bus
);

    sched_state_t r_state;
    logic [31:0]  r_cnt;
    logic         r_ptr;
    logic         r_sel;
    logic         r_we;
    logic         r_launch;
    logic [1:0]   r_iic_call;
    logic [7:0]   r_iic_addr;
    logic [7:0]   r_iic_wdata;
    logic         r_iic_rst_n;
    logic [1:0]   r_done;
    logic [1:0]   r_err;
    logic [7:0]   r_rdata;
    logic         r_busy;

    logic [1:0]   w_gnt;
    logic [31:0]  w_tmo_last;
    logic [31:0]  w_gap_last;
    logic [31:0]  w_abort_last;

    assign w_tmo_last   = TIMEOUT_CYC - 32'd1;
    assign w_gap_last   = WR_GAP_CYC - 32'd1;
    assign w_abort_last = {24'd0, ABORT_CYC} - 32'd1;

    iic_rr_arb2 u_arb (
        .i_req ({bus.req1, bus.req0}),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_ptr       <= 1'b0;
            r_sel       <= 1'b0;
            r_we        <= 1'b0;
            r_launch    <= 1'b0;
            r_iic_call  <= CALL_IDLE;
            r_iic_addr  <= '0;
            r_iic_wdata <= '0;
            r_iic_rst_n <= 1'b1;
            r_done      <= '0;
            r_err       <= '0;
            r_rdata     <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_done <= '0;
            r_err  <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (|w_gnt) begin
                        r_sel       <= w_gnt[1];
                        r_ptr       <= ~w_gnt[1];
                        r_we        <= w_gnt[1] ? bus.we1 : bus.we0;
                        r_iic_addr  <= w_gnt[1] ? bus.addr1 : bus.addr0;
                        r_iic_wdata <= w_gnt[1] ? bus.wdata1 : bus.wdata0;
                        r_launch    <= 1'b1;
                        r_cnt       <= '0;
                        r_busy      <= 1'b1;
                        r_state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Address/data get one cycle of setup before the call goes out;
                    // the timeout window starts at the call edge.
                    if (r_launch) begin
                        r_launch   <= 1'b0;
                        r_iic_call <= call_code(r_we);
                    end else if (bus.iic_done) begin
                        r_iic_call    <= CALL_IDLE;
                        r_done[r_sel] <= 1'b1;
                        r_cnt         <= '0;
                        if (r_we) begin
                            r_state <= ST_GAP;
                        end else begin
                            r_rdata <= bus.iic_rdata;
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end
                    end else if (r_cnt == w_tmo_last) begin
                        r_iic_call  <= CALL_IDLE;
                        r_iic_rst_n <= 1'b0;
                        r_cnt       <= '0;
                        r_state     <= ST_ABORT;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                ST_ABORT: begin
                    if (r_cnt == w_abort_last) begin
                        r_iic_rst_n   <= 1'b1;
                        r_done[r_sel] <= 1'b1;
                        r_err[r_sel]  <= 1'b1;
                        r_cnt         <= '0;
                        r_state       <= ST_GAP;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                ST_GAP: begin
                    if (r_cnt == w_gap_last) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.iic_call  = r_iic_call;
    assign bus.iic_addr  = r_iic_addr;
    assign bus.iic_wdata = r_iic_wdata;
    assign bus.iic_rst_n = r_iic_rst_n;
    assign bus.done0     = r_done[0];
    assign bus.done1     = r_done[1];
    assign bus.err0      = r_err[0];
    assign bus.err1      = r_err[1];
    assign bus.rdata     = r_rdata;
    assign bus.busy      = r_busy;

endmodule
